// File: rtl/test_status_monitor_pkg.sv
// Shared MTC0 status codes and test-monitor channel state encodings.
package test_status_monitor_pkg;

    typedef enum logic [1:0] {
        Mtc0Noop = 2'd0,
        Mtc0Pass = 2'd1,
        Mtc0Fail = 2'd2,
        Mtc0Done = 2'd3
    } mtc0_code_t;

    typedef logic [2:0] test_mon_state_t;

    localparam test_mon_state_t StIdle    = 3'd0;
    localparam test_mon_state_t StRun     = 3'd1;
    localparam test_mon_state_t StDone    = 3'd2;
    localparam test_mon_state_t StFailed  = 3'd3;
    localparam test_mon_state_t StTimeout = 3'd4;

    function automatic logic is_terminal(input test_mon_state_t s);
        return (s == StDone) || (s == StFailed) || (s == StTimeout);
    endfunction

endpackage

// File: rtl/test_mon_channel.sv
// One monitored MTC0 status channel: state machine plus saturating PASS counter.
module test_mon_channel
    import test_status_monitor_pkg::*;
#(
    parameter int unsigned CODE_W = 2,
    parameter int unsigned PASS_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_accept,
    input  logic                  timeout_hit,
    input  logic                  code_valid,
    input  logic [CODE_W-1:0]     code,
    output test_mon_state_t       state,
    output logic [PASS_W-1:0]     pass_count
);

    test_mon_state_t     state_q, state_d;
    logic [PASS_W-1:0]   pass_q, pass_d;

    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        if (start_accept) begin
            state_d = StRun;
            pass_d  = '0;
        end else if (state_q == StRun) begin
            if (code_valid) begin
                if (code == CODE_W'(Mtc0Pass)) begin
                    if (pass_q != '1) pass_d = pass_q + 1'b1;
                end else if (code == CODE_W'(Mtc0Fail)) begin
                    state_d = StFailed;
                end else if (code == CODE_W'(Mtc0Done)) begin
                    state_d = StDone;
                end
            end
            // A FAIL/DONE in the watchdog cycle takes precedence over the timeout.
            if (timeout_hit && state_d == StRun) state_d = StTimeout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            pass_q  <= '0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
        end
    end

    assign state      = state_q;
    assign pass_count = pass_q;

endmodule

// File: rtl/test_status_monitor.sv
// Multi-channel MTC0 pass/done monitor with watchdog and registered global verdict.
// Optional first-failure capture ports are enabled by defining TEST_MON_FAILCAP_EN.
module test_status_monitor
    import test_status_monitor_pkg::*;
#(
    parameter int unsigned NUM_CH         = 2,
    parameter int unsigned CODE_W         = 2,
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned PASS_W         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [NUM_CH-1:0]          code_valid,
    input  logic [NUM_CH*CODE_W-1:0]   code,
    output logic [NUM_CH*3-1:0]        ch_state,
    output logic [NUM_CH*PASS_W-1:0]   pass_count,
    output logic [CNT_W-1:0]           cycle_count,
    output logic                       verdict_valid,
    output logic                       all_done,
    output logic                       any_fail,
    output logic                       timeout
`ifdef TEST_MON_FAILCAP_EN
    ,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] first_fail_ch,
    output logic [CNT_W-1:0]           first_fail_cycle,
    output logic                       first_fail_valid
`endif
);

    test_mon_state_t     st [NUM_CH];
    logic [NUM_CH-1:0]   run_vec, term_vec, done_vec, fail_vec, tmo_vec;
    logic                start_accept, timeout_hit;
    logic [CNT_W-1:0]    cycle_q;
    logic                verdict_q, all_done_q, any_fail_q, timeout_q;

    assign start_accept = start && (run_vec == '0);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        test_mon_channel #(
            .CODE_W (CODE_W),
            .PASS_W (PASS_W)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .start_accept (start_accept),
            .timeout_hit  (timeout_hit),
            .code_valid   (code_valid[i]),
            .code         (code[i*CODE_W +: CODE_W]),
            .state        (st[i]),
            .pass_count   (pass_count[i*PASS_W +: PASS_W])
        );
        assign ch_state[i*3 +: 3] = st[i];
        assign run_vec[i]  = (st[i] == StRun);
        assign term_vec[i] = is_terminal(st[i]);
        assign done_vec[i] = (st[i] == StDone);
        assign fail_vec[i] = (st[i] == StFailed);
        assign tmo_vec[i]  = (st[i] == StTimeout);
    end

    if (TIMEOUT_CYCLES != 0) begin : g_wdog
        assign timeout_hit = (cycle_q == CNT_W'(TIMEOUT_CYCLES));
    end else begin : g_no_wdog
        assign timeout_hit = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst || start_accept) begin
            cycle_q <= '0;
        end else if ((run_vec != '0) && (cycle_q != '1)) begin
            cycle_q <= cycle_q + 1'b1;
        end
    end

    // Flags are derived from the already-registered channel states, hence one edge behind.
    always_ff @(posedge clk) begin
        if (rst || start_accept) begin
            verdict_q  <= 1'b0;
            all_done_q <= 1'b0;
            any_fail_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            verdict_q  <= &term_vec;
            all_done_q <= &done_vec;
            any_fail_q <= |(fail_vec | tmo_vec);
            timeout_q  <= |tmo_vec;
        end
    end

    assign cycle_count   = cycle_q;
    assign verdict_valid = verdict_q;
    assign all_done      = all_done_q;
    assign any_fail      = any_fail_q;
    assign timeout       = timeout_q;

`ifdef TEST_MON_FAILCAP_EN
    localparam int unsigned FailChW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic               ff_hit;
    logic [FailChW-1:0] ff_idx;
    logic [FailChW-1:0] ff_ch_q;
    logic [CNT_W-1:0]   ff_cycle_q;
    logic               ff_valid_q;

    always_comb begin
        ff_hit = 1'b0;
        ff_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (fail_vec[i] || tmo_vec[i]) begin
                ff_hit = 1'b1;
                ff_idx = FailChW'(i);
            end
        end
    end

    // cycle_q here equals the count that became visible together with the failing state.
    always_ff @(posedge clk) begin
        if (rst || start_accept) begin
            ff_ch_q    <= '0;
            ff_cycle_q <= '0;
            ff_valid_q <= 1'b0;
        end else if (!ff_valid_q && ff_hit) begin
            ff_ch_q    <= ff_idx;
            ff_cycle_q <= cycle_q;
            ff_valid_q <= 1'b1;
        end
    end

    assign first_fail_ch    = ff_ch_q;
    assign first_fail_cycle = ff_cycle_q;
    assign first_fail_valid = ff_valid_q;
`endif

endmodule

// File: tb/tb_test_status_monitor.sv
// Directed self-checking bench for test_status_monitor (2 channels, PASS_W=2, watchdog 100).
module tb_test_status_monitor;

    localparam int unsigned NUM_CH = 2;
    localparam int unsigned CODE_W = 2;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned PASS_W = 2;

    localparam logic [1:0] CPass = 2'd1;
    localparam logic [1:0] CFail = 2'd2;
    localparam logic [1:0] CDone = 2'd3;

    logic                       CLOCK_50;
    logic                       rst;
    logic                       start;
    logic [NUM_CH-1:0]          code_valid;
    logic [NUM_CH*CODE_W-1:0]   code;
    logic [NUM_CH*3-1:0]        ch_state;
    logic [NUM_CH*PASS_W-1:0]   pass_count;
    logic [CNT_W-1:0]           cycle_count;
    logic                       verdict_valid, all_done, any_fail, timeout;
`ifdef TEST_MON_FAILCAP_EN
    logic [0:0]                 first_fail_ch;
    logic [CNT_W-1:0]           first_fail_cycle;
    logic                       first_fail_valid;
`endif

    int n_chk = 0;
    int n_bad = 0;
    int edge_n = 0;

    test_status_monitor #(
        .NUM_CH         (NUM_CH),
        .CODE_W         (CODE_W),
        .CNT_W          (CNT_W),
        .PASS_W         (PASS_W),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk           (CLOCK_50),
        .rst           (rst),
        .start         (start),
        .code_valid    (code_valid),
        .code          (code),
        .ch_state      (ch_state),
        .pass_count    (pass_count),
        .cycle_count   (cycle_count),
        .verdict_valid (verdict_valid),
        .all_done      (all_done),
        .any_fail      (any_fail),
        .timeout       (timeout)
`ifdef TEST_MON_FAILCAP_EN
        ,
        .first_fail_ch    (first_fail_ch),
        .first_fail_cycle (first_fail_cycle),
        .first_fail_valid (first_fail_valid)
`endif
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge CLOCK_50);
        #1;
        edge_n++;
    endtask

    task automatic advance_to(input int k);
        while (edge_n < k) tick();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        edge_n = 0;
    endtask

    task automatic send(input int ch, input logic [1:0] c);
        code_valid[ch] = 1'b1;
        code[ch*CODE_W +: CODE_W] = c;
        tick();
        code_valid = '0;
        code = '0;
    endtask

    function automatic logic [2:0] st_of(input int ch);
        return ch_state[ch*3 +: 3];
    endfunction

    function automatic logic [PASS_W-1:0] pc_of(input int ch);
        return pass_count[ch*PASS_W +: PASS_W];
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; code_valid = '0; code = '0;
        tick();
        tick();
        check("rst_state", {58'd0, ch_state}, 64'd0);
        check("rst_flags", {60'd0, verdict_valid, all_done, any_fail, timeout}, 64'd0);
        check("rst_cycle", {32'd0, cycle_count}, 64'd0);
        rst = 1'b0;

        send(0, CFail);
        check("idle_ignores_code", {61'd0, st_of(0)}, 64'd0);

        // Both channels finish cleanly.
        do_start();
        check("start_run", {58'd0, ch_state}, 64'b001_001);
        check("start_cycle0", {32'd0, cycle_count}, 64'd0);
        advance_to(9);
        send(0, CDone);
        check("t1_ch0_done", {61'd0, st_of(0)}, 64'd2);
        advance_to(19);
        send(1, CDone);
        check("t1_verdict_lag", {63'd0, verdict_valid}, 64'd0);
        tick();
        check("t1_verdict", {60'd0, verdict_valid, all_done, any_fail, timeout}, 64'b1100);
        check("t1_cycle", {32'd0, cycle_count}, 64'd20);

        // PASS counting with a failing neighbour; code in the start cycle is ignored.
        code_valid[0] = 1'b1;
        code[1:0] = CFail;
        do_start();
        code_valid = '0;
        code = '0;
        check("t2_start_code_ignored", {61'd0, st_of(0)}, 64'd1);
        send(0, CPass);
        send(0, CPass);
        check("t2_pass2", {62'd0, pc_of(0)}, 64'd2);
        send(0, CPass);
        send(0, CDone);
        send(1, CFail);
        tick();
        check("t2_pass3", {62'd0, pc_of(0)}, 64'd3);
        check("t2_ch1_pass", {62'd0, pc_of(1)}, 64'd0);
        check("t2_ch1_failed", {61'd0, st_of(1)}, 64'd3);
        check("t2_flags", {60'd0, verdict_valid, all_done, any_fail, timeout}, 64'b1010);
`ifdef TEST_MON_FAILCAP_EN
        check("t2_ff", {31'd0, first_fail_valid, 31'd0, first_fail_ch}, {31'd0, 1'b1, 32'd1});
        check("t2_ff_cycle", {32'd0, first_fail_cycle}, 64'd5);
`endif

        // Watchdog: ch1 never reports.
        do_start();
        advance_to(2);
        send(0, CDone);
        advance_to(100);
        check("t3_pre_tmo", {61'd0, st_of(1)}, 64'd1);
        check("t3_pre_cycle", {32'd0, cycle_count}, 64'd100);
        tick();
        check("t3_ch1_tmo", {61'd0, st_of(1)}, 64'd4);
        tick();
        check("t3_flags", {60'd0, verdict_valid, all_done, any_fail, timeout}, 64'b1011);
        check("t3_cycle_hold", {32'd0, cycle_count}, 64'd101);
`ifdef TEST_MON_FAILCAP_EN
        check("t3_ff_ch", {63'd0, first_fail_ch}, 64'd1);
`endif

        // DONE on the watchdog edge beats the timeout.
        do_start();
        send(1, CDone);
        advance_to(100);
        send(0, CDone);
        check("t4_ch0_done", {61'd0, st_of(0)}, 64'd2);
        tick();
        check("t4_flags", {60'd0, verdict_valid, all_done, any_fail, timeout}, 64'b1100);

        // PASS saturation at 2^PASS_W-1.
        do_start();
        for (int i = 0; i < 5; i++) send(0, CPass);
        check("t5_pass_sat", {62'd0, pc_of(0)}, 64'd3);

        // start while running is ignored; rst beats a simultaneous start.
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t6_start_ignored", {32'd0, cycle_count}, 64'd7);
        check("t6_still_run", {58'd0, ch_state}, 64'b001_001);
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        check("t6_rst_state", {58'd0, ch_state}, 64'd0);
        check("t6_rst_cnt", {28'd0, pass_count, cycle_count}, 64'd0);
        tick();
        check("t6_rst_flags", {60'd0, verdict_valid, all_done, any_fail, timeout}, 64'd0);
        check("t6_stay_idle", {58'd0, ch_state}, 64'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/test_status_monitor.md
Name: test_status_monitor

Overview:
- Synthesisable, parametrised successor to the single-core "wait for MTC0_FAIL/MTC0_DONE" completion check.
- Watches NUM_CH independent pass_done MTC0 status channels, one per core or test context.
- Tracks per-channel state and PASS counts, enforces a watchdog timeout, and produces a registered global verdict.
- Sits beside mips_cpu: usable in the testbench and on FPGA to drive LEDs/status registers.

Parameters:
- NUM_CH, 2, number of monitored status channels (1..16)
- CODE_W, 2, width of one MTC0 code
- CNT_W, 32, width of global cycle counter
- PASS_W, 8, width of per-channel PASS counter
- TIMEOUT_CYCLES, 0, watchdog limit in cycles; 0 disables the watchdog

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; arms all channels (soft-reset release)
- code_valid  in  NUM_CH  per-channel MTC0 write strobe
- code  in  NUM_CH*CODE_W  per-channel MTC0 code; channel i at [i*CODE_W +: CODE_W]
- ch_state  out  NUM_CH*3  per-channel state encoding
- pass_count  out  NUM_CH*PASS_W  per-channel PASS event count
- cycle_count  out  CNT_W  cycles since start
- verdict_valid  out  1  all channels terminal
- all_done  out  1  verdict_valid and every channel DONE
- any_fail  out  1  some channel FAILED or TIMEOUT
- timeout  out  1  some channel TIMEOUT

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Code encoding: NOOP=0, PASS=1, FAIL=2, DONE=3.
- Channel states: IDLE=0, RUN=1, DONE=2, FAILED=3, TIMEOUT=4.
- Reset (rst wins over everything):
  - all channels IDLE
  - all counters 0
  - every output 0
- start:
  - Accepted only when no channel is in RUN.
  - Takes effect at the next edge: all channels go to RUN; pass_count, cycle_count and all flags clear.
  - start while any channel is in RUN is ignored.
  - start after a verdict re-arms the block.
- In RUN, on code_valid[i]:
  - PASS: pass_count[i]+1, saturating at 2^PASS_W-1.
  - FAIL: FAILED.
  - DONE: DONE.
  - NOOP: no effect.
- code_valid on a channel in IDLE or any terminal state is ignored, including in the start cycle.
- cycle_count:
  - 0 in the cycle after start.
  - Increments every cycle while any channel is in RUN.
  - Saturates at all-ones.
  - Holds its value once no channel is in RUN.
- Watchdog (TIMEOUT_CYCLES>0): when cycle_count==TIMEOUT_CYCLES, every channel still in RUN moves to TIMEOUT at that edge.
- Code event and timeout in the same cycle: the code event wins.
- Latency:
  - A code event sampled at edge N is visible on ch_state after N.
  - verdict_valid, all_done, any_fail and timeout are registered and update after edge N+1.
- Flags hold until rst or the next accepted start.
- Width rule: counters are unsigned; no wrap anywhere.

Optional Feature:
- Macro: TEST_MON_FAILCAP_EN.
- Defined:
  - Adds outputs first_fail_ch (clog2(NUM_CH), min 1 bit), first_fail_cycle (CNT_W) and first_fail_valid (1).
  - They capture the channel index and cycle_count of the first FAIL or TIMEOUT after start.
  - If several channels fail in the same cycle, the lowest index wins.
  - Sticky until rst or start; reset value 0.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Shared header mips_cpu.svh:
  - mtc0 code enum (MTC0_NOOP/PASS/FAIL/DONE)
  - test_mon_state_t enum
- Natural sub-module: test_mon_channel, holding the per-channel FSM and PASS counter.
  - Inputs: start_accept, timeout_hit, code_valid, code.
  - Instantiated NUM_CH times via generate.
- The top level owns cycle_count, the watchdog compare, verdict registers and fail capture.

Test Plan:
- Reset then start; ch0 DONE at cycle 10, ch1 DONE at cycle 20 -> verdict_valid=1 two edges after the ch1 event, all_done=1, any_fail=0, cycle_count=20.
- ch0 sends PASS x3 then DONE; ch1 sends FAIL at cycle 5 -> pass_count[0]=3, ch1 FAILED, any_fail=1, all_done=0; with TEST_MON_FAILCAP_EN: first_fail_ch=1, first_fail_cycle=5.
- TIMEOUT_CYCLES=100, ch1 never reports -> ch1 TIMEOUT at cycle_count=100, timeout=1, verdict_valid=1.
- ch0 DONE in the same cycle cycle_count==100 -> ch0 DONE, not TIMEOUT.
- PASS_W=2, 5 PASS events -> pass_count saturates at 3.
- rst asserted mid-RUN with a simultaneous start -> all outputs 0, states IDLE; start while RUN ignored (cycle_count not cleared).
